// File: rtl/mcu_strip_reader.sv
// mcu_strip_reader
//
// Reads a completed strip (8 rows x width_pix pixels) out of the back half of
// the ingester's double-buffered EBR bank and streams it MCU by MCU: MCU 0 up
// to MCU width_pix/8-1, each as 64 pixels in row-major order.
//
// Ports
//   clock               system clock, all logic on the rising edge
//   reset               synchronous, active-high
//   frontbuffer_select  half the ingester is writing; a toggle marks the other
//                       half as complete
//   rd_block_select     EBR index being read (mcu % num_ebr)
//   rd_buffer_select    buffer half being read
//   rd_addr             EBR address {mcu / num_ebr, py, px}
//   rd_en               read strobe; rd_data is valid one cycle later
//   rd_data             registered EBR read data
//   pix_data/pix_valid  output pixel stream, accepted when pix_ready is high
//   pix_ready           consumer ready
//   mcu_first/mcu_last  pixel 0 / pixel 63 of an MCU (qualified by pix_valid)
//   strip_last          last pixel of the strip
//   frame_last          strip_last of the last strip in the frame
//   overrun             sticky: a new strip arrived while one was in progress
module mcu_strip_reader #(
  parameter int width_pix  = 320,
  parameter int height_pix = 240,
  parameter int num_ebr    = 5,
  parameter int ebr_size   = 512
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frontbuffer_select,
  output logic [$clog2(num_ebr)-1:0]  rd_block_select,
  output logic                        rd_buffer_select,
  output logic [$clog2(ebr_size)-1:0] rd_addr,
  output logic                        rd_en,
  input  logic [7:0]                  rd_data,
  output logic [7:0]                  pix_data,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic                        mcu_first,
  output logic                        mcu_last,
  output logic                        strip_last,
  output logic                        frame_last,
  output logic                        overrun
);

  localparam int MCUS    = width_pix / 8;
  localparam int STRIPS  = height_pix / 8;
  localparam int ADDR_W  = $clog2(ebr_size);
  localparam int BLK_W   = $clog2(num_ebr);
  localparam int GRP_W   = ADDR_W - 6;
  localparam int MCU_W   = $clog2(MCUS);
  localparam int STRIP_W = $clog2(STRIPS);

  localparam logic [MCU_W-1:0]   MCU_MAX   = MCU_W'(MCUS - 1);
  localparam logic [MCU_W-1:0]   MCU_ONE   = MCU_W'(1);
  localparam logic [BLK_W-1:0]   BLK_MAX   = BLK_W'(num_ebr - 1);
  localparam logic [BLK_W-1:0]   BLK_ONE   = BLK_W'(1);
  localparam logic [GRP_W-1:0]   GRP_ONE   = GRP_W'(1);
  localparam logic [STRIP_W-1:0] STRIP_MAX = STRIP_W'(STRIPS - 1);
  localparam logic [STRIP_W-1:0] STRIP_ONE = STRIP_W'(1);

  // FIFO entry layout: {mcu_first, mcu_last, strip_last, data[7:0]}
  localparam int          ENTRY_W    = 11;
  localparam logic [10:0] ENTRY_ZERO = 11'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic                 fb_prev_r;
  logic                 pending_r;
  logic                 rd_buf_r;
  logic                 overrun_r;

  logic [2:0]           px_r;
  logic [2:0]           py_r;
  logic [MCU_W-1:0]     mcu_r;
  logic [BLK_W-1:0]     blk_r;
  logic [GRP_W-1:0]     grp_r;

  logic                 inflight_r;
  logic [2:0]           mk_inflight_r;
  logic [ENTRY_W-1:0]   fifo_mem_r [0:1];
  logic                 wr_ptr_r;
  logic                 rd_ptr_r;
  logic [1:0]           count_r;
  logic [STRIP_W-1:0]   strip_r;

  logic                 toggle_s;
  logic                 start_s;
  logic                 fifo_nonempty_s;
  logic                 pix_valid_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 fifo_pop_s;
  logic [1:0]           occupancy_s;
  logic                 issue_s;
  logic                 px_wrap_s;
  logic                 py_wrap_s;
  logic                 mcu_wrap_s;
  logic                 blk_wrap_s;
  logic                 last_issue_s;
  logic [2:0]           mk_issue_s;
  logic [ENTRY_W-1:0]   out_s;

  // Handshake, occupancy and issue qualification.
  always_comb begin
    toggle_s        = (fb_prev_r != frontbuffer_select);
    start_s         = (state_r == ST_IDLE) && pending_r;
    fifo_nonempty_s = (count_r != 2'd0);
    pix_valid_s     = fifo_nonempty_s || inflight_r;
    pop_s           = pix_valid_s && pix_ready;
    // A same-cycle pop frees a slot, which keeps a steady one-per-cycle stream.
    occupancy_s     = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    issue_s         = (state_r == ST_READ) && (occupancy_s < 2'd2);
    // In-flight data bypasses the FIFO when it is empty and the consumer takes it.
    fifo_pop_s      = pop_s && fifo_nonempty_s;
    push_s          = inflight_r && !(pop_s && !fifo_nonempty_s);
  end

  // Read-counter wrap detection and the markers attached to each issued read.
  always_comb begin
    px_wrap_s    = (px_r == 3'd7);
    py_wrap_s    = (py_r == 3'd7);
    mcu_wrap_s   = (mcu_r == MCU_MAX);
    blk_wrap_s   = (blk_r == BLK_MAX);
    last_issue_s = px_wrap_s && py_wrap_s && mcu_wrap_s;
    mk_issue_s   = {(px_r == 3'd0) && (py_r == 3'd0),
                    px_wrap_s && py_wrap_s,
                    last_issue_s};
  end

  // Next-state logic for the strip sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pending_r) state_s = ST_READ;
        else           state_s = ST_IDLE;
      end
      ST_READ: begin
        if (issue_s && last_issue_s) state_s = ST_DRAIN;
        else                         state_s = ST_READ;
      end
      ST_DRAIN: begin
        if (!fifo_nonempty_s && !inflight_r) state_s = ST_IDLE;
        else                                 state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, toggle detection, pending strip, buffer half and overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      fb_prev_r <= frontbuffer_select;
      pending_r <= 1'b0;
      rd_buf_r  <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      fb_prev_r <= frontbuffer_select;
      if (toggle_s) begin
        pending_r <= 1'b1;
      end else if (start_s) begin
        pending_r <= 1'b0;
      end
      // The half only moves while idle, so it stays fixed for a whole strip;
      // relatching on IDLE->READ picks up the newest half after an overrun.
      if ((state_r == ST_IDLE) && (toggle_s || pending_r)) begin
        rd_buf_r <= ~frontbuffer_select;
      end
      if (toggle_s && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Read address counters: px, then py, then mcu with its block/group split.
  always_ff @(posedge clock) begin
    if (reset) begin
      px_r  <= 3'd0;
      py_r  <= 3'd0;
      mcu_r <= '0;
      blk_r <= '0;
      grp_r <= '0;
    end else if (issue_s) begin
      px_r <= px_r + 3'd1;
      if (px_wrap_s) begin
        py_r <= py_r + 3'd1;
        if (py_wrap_s) begin
          if (mcu_wrap_s) begin
            mcu_r <= '0;
            blk_r <= '0;
            grp_r <= '0;
          end else begin
            mcu_r <= mcu_r + MCU_ONE;
            if (blk_wrap_s) begin
              blk_r <= '0;
              grp_r <= grp_r + GRP_ONE;
            end else begin
              blk_r <= blk_r + BLK_ONE;
            end
          end
        end
      end
    end
  end

  // In-flight read tracking and the 2-entry output FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_r    <= 1'b0;
      mk_inflight_r <= 3'd0;
      fifo_mem_r[0] <= ENTRY_ZERO;
      fifo_mem_r[1] <= ENTRY_ZERO;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        mk_inflight_r <= mk_issue_s;
      end
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {mk_inflight_r, rd_data};
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_s} - {1'b0, fifo_pop_s};
    end
  end

  // Strip position within the frame, advanced when the last pixel of a strip is taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      strip_r <= '0;
    end else if (pop_s && out_s[8]) begin
      if (strip_r == STRIP_MAX) strip_r <= '0;
      else                      strip_r <= strip_r + STRIP_ONE;
    end
  end

  // Output head: FIFO head first, otherwise the read landing this cycle, otherwise zero.
  always_comb begin
    out_s = ENTRY_ZERO;
    if (fifo_nonempty_s) begin
      out_s = fifo_mem_r[rd_ptr_r];
    end else if (inflight_r) begin
      out_s = {mk_inflight_r, rd_data};
    end else begin
      out_s = ENTRY_ZERO;
    end
  end

  assign rd_block_select  = blk_r;
  assign rd_buffer_select = rd_buf_r;
  assign rd_addr          = {grp_r, py_r, px_r};
  assign rd_en            = issue_s;
  assign pix_data         = out_s[7:0];
  assign pix_valid        = pix_valid_s;
  assign mcu_first        = out_s[10];
  assign mcu_last         = out_s[9];
  assign strip_last       = out_s[8];
  assign frame_last       = out_s[8] && (strip_r == STRIP_MAX);
  assign overrun          = overrun_r;

endmodule

// File: tb/tb_mcu_strip_reader.sv
// Directed testbench for mcu_strip_reader with a behavioural double-buffered
// EBR bank (registered read data, one cycle after rd_en).
module tb_mcu_strip_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       frontbuffer_select;
  logic [2:0] rd_block_select;
  logic       rd_buffer_select;
  logic [8:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data = 8'd0;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       mcu_first;
  logic       mcu_last;
  logic       strip_last;
  logic       frame_last;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;
  int strip_idx = 0;

  logic [7:0]  ebr [0:1][0:4][0:511];
  logic [27:0] all_out;

  assign all_out = {rd_block_select, rd_buffer_select, rd_addr, rd_en, pix_data,
                    pix_valid, mcu_first, mcu_last, strip_last, frame_last, overrun};

  mcu_strip_reader dut (
    .clock              (clock),
    .reset              (reset),
    .frontbuffer_select (frontbuffer_select),
    .rd_block_select    (rd_block_select),
    .rd_buffer_select   (rd_buffer_select),
    .rd_addr            (rd_addr),
    .rd_en              (rd_en),
    .rd_data            (rd_data),
    .pix_data           (pix_data),
    .pix_valid          (pix_valid),
    .pix_ready          (pix_ready),
    .mcu_first          (mcu_first),
    .mcu_last           (mcu_last),
    .strip_last         (strip_last),
    .frame_last         (frame_last),
    .overrun            (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rd_en) rd_data <= ebr[rd_buffer_select][rd_block_select][rd_addr];
  end

  // Half 0 holds (block*512 + addr) mod 256; half 1 the same pattern xor A5.
  function automatic logic [7:0] pat(input logic half, input int b, input int a);
    int v;
    v = (b * 512 + a) % 256;
    if (half) v = v ^ 165;
    return 8'(v);
  endfunction

  // {block[2:0], addr[8:0]} of the k-th read / pixel of a strip.
  function automatic logic [11:0] exp_loc(input int k);
    int mcu, py, px, blk, addr;
    mcu  = k / 64;
    py   = (k % 64) / 8;
    px   = k % 8;
    blk  = mcu % 5;
    addr = (mcu / 5) * 64 + py * 8 + px;
    return {3'(blk), 9'(addr)};
  endfunction

  // {frame_last, mcu_first, mcu_last, strip_last, data} for pixel n.
  function automatic logic [11:0] exp_pix(input int n, input logic half, input int sidx);
    logic [11:0] loc;
    logic        fi, la, sl, fr;
    loc = exp_loc(n);
    fi  = (n % 64 == 0);
    la  = (n % 64 == 63);
    sl  = (n == 2559);
    fr  = sl && (sidx == 29);
    return {fr, fi, la, sl, pat(half, int'(loc[11:9]), int'(loc[8:0]))};
  endfunction

  // Runs one strip (or its first n_target pixels), checking reads and pixels.
  task automatic run_strip(input logic exp_half, input bit toggle_first, input int ready_pct,
                           input int toggle_at, input int n_target, input bit check_gap);
    int          n, k, first_rd, first_val, tog_cyc;
    logic        prev_hold;
    logic [11:0] prev_word, cur_word, exp_word;
    logic [12:0] rd_word, exp_rd;
    n = 0; k = 0; first_rd = -1; first_val = -1; tog_cyc = -1;
    prev_hold = 1'b0; prev_word = 12'd0;
    for (int cyc = 0; cyc < 20000 && n < n_target; cyc++) begin
      @(posedge clock);
      #1;
      if (cyc == 0 && toggle_first) frontbuffer_select = ~frontbuffer_select;
      if (toggle_at >= 0 && n == toggle_at && tog_cyc < 0) begin
        frontbuffer_select = ~frontbuffer_select;
        tog_cyc = cyc;
      end
      if (ready_pct >= 100) pix_ready = 1'b1;
      else pix_ready = (int'($urandom_range(99)) < ready_pct) ? 1'b1 : 1'b0;
      @(negedge clock);
      cur_word = {frame_last, mcu_first, mcu_last, strip_last, pix_data};
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        rd_word = {rd_buffer_select, rd_block_select, rd_addr};
        exp_rd  = {exp_half, exp_loc(k)};
        n_vec++;
        if (k >= 2560 || rd_word !== exp_rd) begin
          n_err++;
          $display("FAIL read_addr issue %0d: got {buf,blk,addr}=%h want %h", k, rd_word, exp_rd);
        end
        k++;
      end
      if (prev_hold) begin
        n_vec++;
        if ({pix_valid, cur_word} !== {1'b1, prev_word}) begin
          n_err++;
          $display("FAIL stall_hold pixel %0d: got %h want %h", n, {pix_valid, cur_word}, {1'b1, prev_word});
        end
      end
      if (pix_valid && first_val < 0) first_val = cyc;
      if (pix_valid && pix_ready) begin
        exp_word = exp_pix(n, exp_half, strip_idx);
        n_vec++;
        if (cur_word !== exp_word) begin
          n_err++;
          $display("FAIL pixel %0d strip %0d: got {fr,first,last,slast,data}=%h want %h",
                   n, strip_idx, cur_word, exp_word);
        end
        n++;
      end
      if (tog_cyc >= 0 && cyc == tog_cyc + 2) begin
        n_vec++;
        if (overrun !== 1'b1) begin
          n_err++;
          $display("FAIL overrun_set: got %b want 1", overrun);
        end
      end
      prev_hold = pix_valid && !pix_ready;
      prev_word = cur_word;
    end
    n_vec++;
    if (n != n_target) begin
      n_err++;
      $display("FAIL pixel_count: got %0d want %0d (cycle budget expired)", n, n_target);
    end
    if (toggle_first) begin
      n_vec++;
      if (first_rd != 2 || first_val != 3) begin
        n_err++;
        $display("FAIL start_latency: got rd_en@%0d pix_valid@%0d want 2 and 3", first_rd, first_val);
      end
    end
    if (check_gap) begin
      n_vec++;
      if (first_val < 2) begin
        n_err++;
        $display("FAIL strip_gap: got %0d idle cycles want >= 2", first_val);
      end
    end
    if (n_target == 2560) begin
      n_vec++;
      if (k != 2560) begin
        n_err++;
        $display("FAIL read_count: got %0d want 2560", k);
      end
      strip_idx = (strip_idx == 29) ? 0 : strip_idx + 1;
    end
  endtask

  task automatic test_reset_idle;
    reset = 1'b1;
    frontbuffer_select = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if (all_out !== 28'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      n_vec++;
      if ({rd_en, pix_valid, overrun} !== 3'b000) begin
        n_err++;
        $display("FAIL idle cycle %0d: got {rd_en,valid,overrun}=%b want 000", i, {rd_en, pix_valid, overrun});
      end
    end
  endtask

  task automatic test_single_strip;
    repeat (4) @(posedge clock);
    run_strip(frontbuffer_select, 1'b1, 100, -1, 2560, 1'b0);
  endtask

  task automatic test_backpressure;
    repeat (4) @(posedge clock);
    run_strip(frontbuffer_select, 1'b1, 70, -1, 2560, 1'b0);
    pix_ready = 1'b1;
  endtask

  task automatic test_overrun;
    repeat (4) @(posedge clock);
    run_strip(frontbuffer_select, 1'b1, 100, 1000, 2560, 1'b0);
    // The queued strip reads the half opposite the latest front buffer.
    run_strip(~frontbuffer_select, 1'b0, 100, -1, 2560, 1'b1);
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_frame_wrap;
    int guard;
    guard = 0;
    do begin
      repeat (4) @(posedge clock);
      run_strip(frontbuffer_select, 1'b1, 100, -1, 2560, 1'b0);
      guard++;
    end while (strip_idx != 0 && guard < 40);
    // First strip of the next frame: frame_last must stay low.
    repeat (4) @(posedge clock);
    run_strip(frontbuffer_select, 1'b1, 100, -1, 2560, 1'b0);
  endtask

  task automatic test_mid_reset;
    repeat (4) @(posedge clock);
    run_strip(frontbuffer_select, 1'b1, 100, -1, 500, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (all_out !== 28'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %h want 0", all_out);
    end
    strip_idx = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_vec++;
      if ({rd_en, pix_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL post_reset_idle cycle %0d: got %b want 00", i, {rd_en, pix_valid});
      end
    end
    run_strip(frontbuffer_select, 1'b1, 100, -1, 2560, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    frontbuffer_select = 1'b0;
    pix_ready = 1'b0;
    for (int h = 0; h < 2; h++)
      for (int b = 0; b < 5; b++)
        for (int a = 0; a < 512; a++)
          ebr[h][b][a] = pat(h[0], b, a);
    test_reset_idle();
    test_single_strip();
    test_backpressure();
    test_overrun();
    test_frame_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
